// File: rtl/p_bit.sv
// Probabilistic bit: xorshift32 sample compared against a tanh-shaped activation of I_i.
// Define PBIT_TANH_LUT_EN for the rounded-tanh ROM; otherwise a hard-tanh (saturating x16) is used.
module p_bit (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic signed [7:0] I_i,
  input  logic [31:0]       seed,
  output logic              m_i
);

  localparam logic [31:0] SeedFallback = 32'h2545F491;

  logic [31:0]       x_q, x_d;
  logic [31:0]       x_s1, x_s2, x_next;
  logic              m_q, m_d;
  logic signed [7:0] t;
  logic signed [7:0] r;

  always_comb begin
    x_s1   = x_q ^ (x_q << 13);
    x_s2   = x_s1 ^ (x_s1 >> 17);
    x_next = x_s2 ^ (x_s2 << 5);
  end

  assign r = x_q[7:0];

`ifdef PBIT_TANH_LUT_EN
  logic [7:0] mag;
  logic [6:0] lut;

  // tanh is odd, so only magnitudes are stored; |I_i| >= 25 rounds to 127.
  always_comb begin
    mag = I_i[7] ? 8'(-I_i) : 8'(I_i);
    case (mag)
      8'd0:    lut = 7'd0;
      8'd1:    lut = 7'd16;
      8'd2:    lut = 7'd31;
      8'd3:    lut = 7'd46;
      8'd4:    lut = 7'd59;
      8'd5:    lut = 7'd70;
      8'd6:    lut = 7'd81;
      8'd7:    lut = 7'd89;
      8'd8:    lut = 7'd97;
      8'd9:    lut = 7'd103;
      8'd10:   lut = 7'd108;
      8'd11:   lut = 7'd112;
      8'd12:   lut = 7'd115;
      8'd13:   lut = 7'd118;
      8'd14:   lut = 7'd120;
      8'd15:   lut = 7'd121;
      8'd16:   lut = 7'd122;
      8'd17:   lut = 7'd123;
      8'd18:   lut = 7'd124;
      8'd19:   lut = 7'd125;
      8'd20:   lut = 7'd125;
      8'd21:   lut = 7'd126;
      8'd22:   lut = 7'd126;
      8'd23:   lut = 7'd126;
      8'd24:   lut = 7'd126;
      default: lut = 7'd127;
    endcase
    t = I_i[7] ? 8'(-{1'b0, lut}) : {1'b0, lut};
  end
`else
  logic signed [11:0] scaled;

  always_comb begin
    scaled = $signed({I_i, 4'b0000});
    if (scaled > 12'sd127) begin
      t = 8'sd127;
    end else if (scaled < -12'sd127) begin
      t = -8'sd127;
    end else begin
      t = scaled[7:0];
    end
  end
`endif

  // 9-bit signed compare keeps t > r free of overflow at the range ends.
  always_comb begin
    m_d = m_q;
    x_d = x_q;
    if (enable) begin
      m_d = $signed({t[7], t}) > $signed({r[7], r});
      x_d = x_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q <= (seed == 32'd0) ? SeedFallback : seed;
      m_q <= 1'b0;
    end else begin
      x_q <= x_d;
      m_q <= m_d;
    end
  end

  assign m_i = m_q;

endmodule

// File: tb/tb_p_bit.sv
// Self-checking bench for p_bit against a behavioural xorshift/activation model.
module tb_p_bit;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic signed [7:0] I_i;
  logic [31:0]       seed;
  logic              m_i;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mx;

  p_bit dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .I_i    (I_i),
    .seed   (seed),
    .m_i    (m_i)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] xs(input logic [31:0] x);
    logic [31:0] v;
    v = x;
    v = v ^ (v << 13);
    v = v ^ (v >> 17);
    v = v ^ (v << 5);
    return v;
  endfunction

  function automatic int model_t(input int i);
    int v;
`ifdef PBIT_TANH_LUT_EN
    real rv;
    rv = 127.0 * $tanh(real'(i) / 8.0);
    v  = $rtoi(rv + ((rv >= 0.0) ? 0.5 : -0.5));
`else
    v = i * 16;
`endif
    if (v > 127) v = 127;
    if (v < -127) v = -127;
    return v;
  endfunction

  // Model one enabled update: sample from the current state, then advance it.
  task automatic model_step(input int i, output logic m);
    int r;
    r  = int'($signed(mx[7:0]));
    m  = (model_t(i) > r);
    mx = xs(mx);
  endtask

  task automatic drive(input logic en, input logic signed [7:0] iv);
    enable = en;
    I_i    = iv;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [31:0] s);
    reset  = 1'b1;
    seed   = s;
    enable = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    seed  = $urandom;
    mx    = (s == 32'd0) ? 32'h2545F491 : s;
  endtask

  task automatic run_checked(input string name, input int n);
    logic exp;
    logic signed [7:0] iv;
    for (int k = 0; k < n; k++) begin
      iv = 8'($urandom);
      model_step(int'(iv), exp);
      drive(1'b1, iv);
      checks++;
      if (m_i !== exp) begin
        failures++;
        $display("FAIL %s step %0d I=%0d: m_i=%b expected=%b", name, k, iv, m_i, exp);
      end
    end
  endtask

  task automatic test_reset;
    do_reset(32'h1234_5678);
    checks++;
    if (m_i !== 1'b0) begin
      failures++;
      $display("FAIL reset_value: m_i=%b expected=0", m_i);
    end
  endtask

  task automatic test_seed_one;
    do_reset(32'd1);
    drive(1'b1, 8'sd0);
    checks++;
    if (m_i !== 1'b0) begin
      failures++;
      $display("FAIL seed1_first: m_i=%b expected=0", m_i);
    end
    // Continue from the documented post-step state, independent of the model's step.
    mx = 32'h00042021;
    run_checked("seed1_follow", 32);
  endtask

  task automatic test_seed_80;
    do_reset(32'h80);
    drive(1'b1, 8'sd0);
    checks++;
    if (m_i !== 1'b1) begin
      failures++;
      $display("FAIL seed80_first: m_i=%b expected=1", m_i);
    end
  endtask

  task automatic test_seed_zero;
    logic exp;
    int   toggles;
    logic prev;
    do_reset(32'd0);
    toggles = 0;
    prev    = m_i;
    for (int k = 0; k < 1000; k++) begin
      model_step(0, exp);
      drive(1'b1, 8'sd0);
      checks++;
      if (m_i !== exp) begin
        failures++;
        $display("FAIL seed0_seq step %0d: m_i=%b expected=%b", k, m_i, exp);
      end
      if (m_i !== prev) toggles++;
      prev = m_i;
    end
    checks++;
    if (toggles == 0) begin
      failures++;
      $display("FAIL seed0_toggle: toggles=%0d expected>=1", toggles);
    end
  endtask

  task automatic prob_run(input string name, input logic signed [7:0] iv, input int lo,
                          input int hi);
    int ones;
    do_reset($urandom | 32'd1);
    ones = 0;
    for (int k = 0; k < 1000; k++) begin
      drive(1'b1, iv);
      if (m_i === 1'b1) ones++;
    end
    checks++;
    if (ones < lo || ones > hi) begin
      failures++;
      $display("FAIL %s: ones=%0d expected %0d..%0d", name, ones, lo, hi);
    end
  endtask

  task automatic test_probability;
    prob_run("prob_max", 8'sh7F, 990, 1000);
    prob_run("prob_min", -8'sd128, 0, 10);
    prob_run("prob_zero", 8'sd0, 450, 550);
  endtask

  task automatic test_sweep;
    logic exp;
    do_reset($urandom);
    for (int i = -128; i < 128; i++) begin
      model_step(i, exp);
      drive(1'b1, 8'(i));
      checks++;
      if (m_i !== exp) begin
        failures++;
        $display("FAIL sweep I=%0d: m_i=%b expected=%b", i, m_i, exp);
      end
    end
  endtask

  task automatic test_hold;
    logic held;
    do_reset($urandom);
    run_checked("hold_pre", 17);
    held = m_i;
    for (int k = 0; k < 100; k++) begin
      drive(1'b0, 8'($urandom));
      checks++;
      if (m_i !== held) begin
        failures++;
        $display("FAIL hold_cycle %0d: m_i=%b expected=%b", k, m_i, held);
      end
    end
    run_checked("hold_post", 20);
  endtask

  task automatic test_reset_midrun;
    logic [31:0]       s;
    logic signed [7:0] ivs[40];
    logic              first[40];
    logic              exp;
    s = $urandom | 32'd1;
    do_reset(s);
    for (int k = 0; k < 40; k++) begin
      ivs[k] = 8'($urandom);
      model_step(int'(ivs[k]), exp);
      drive(1'b1, ivs[k]);
      first[k] = m_i;
      checks++;
      if (m_i !== exp) begin
        failures++;
        $display("FAIL midrun_first step %0d: m_i=%b expected=%b", k, m_i, exp);
      end
    end
    for (int k = 0; k < 10; k++) drive(1'b1, 8'($urandom));
    // Force m_i high before the reset so the clear is observable.
    drive(1'b1, 8'sh7F);
    reset  = 1'b1;
    seed   = s;
    enable = 1'b1;
    I_i    = 8'sh7F;
    @(posedge clk);
    #1;
    checks++;
    if (m_i !== 1'b0) begin
      failures++;
      $display("FAIL midrun_reset: m_i=%b expected=0", m_i);
    end
    reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      drive(1'b1, ivs[k]);
      checks++;
      if (m_i !== first[k]) begin
        failures++;
        $display("FAIL midrun_replay step %0d: m_i=%b expected=%b", k, m_i, first[k]);
      end
    end
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    I_i    = 8'sd0;
    seed   = 32'd1;
    mx     = 32'd1;
    @(posedge clk);
    #1;
    test_reset();
    test_seed_one();
    test_seed_80();
    test_seed_zero();
    test_probability();
    test_sweep();
    test_hold();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
